// File: rtl/slave.sv
// Stream slave: compacts kept lanes of each accepted beat into a packed entry, behind
// an output register plus one skid register. Optional counters under SLAVE_STATS_EN.
module slave_lane #(
  parameter int KW   = 3,
  parameter int DW   = 1,
  parameter int LANE = 0
) (
  input  logic [KW-1:0]         keep,
  input  logic                  last,
  input  logic [KW-1:0][DW-1:0] data,
  output logic [DW+1:0]         ent
);
  // Output lane LANE takes the LANE-th kept input lane; last goes only on the top kept lane.
  always_comb begin
    int n;
    int tot;
    ent = '0;
    n   = 0;
    tot = 0;
    for (int i = 0; i < KW; i++) tot += int'(keep[i]);
    for (int i = 0; i < KW; i++) begin
      if (keep[i]) begin
        if (n == LANE) begin
          ent[0]      = 1'b1;
          ent[1]      = last && (tot == LANE + 1);
          ent[DW+1:2] = data[i];
        end
        n++;
      end
    end
    if (LANE == 0 && tot == 0) ent[1] = last;
  end
endmodule

module slave #(
  parameter int S_KEEP_WIDTH    = 3,
  parameter int T_DATA_WIDTH    = 1,
  parameter int BUF_IN_ENTRY_SZ = (2 + T_DATA_WIDTH) * S_KEEP_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic                       s_last_i,
  input  logic [S_KEEP_WIDTH-1:0]    s_keep_i,
  input  logic [T_DATA_WIDTH-1:0]    s_data_i [S_KEEP_WIDTH],
  input  logic                       overflow,
  output logic                       slave_entry_valid,
  output logic [BUF_IN_ENTRY_SZ-1:0] slave_entry,
  output logic                       in_packet_o
`ifdef SLAVE_STATS_EN
  ,
  output logic [15:0]                pkt_cnt_o,
  output logic [15:0]                drop_cnt_o
`endif
);
  localparam int LW = 2 + T_DATA_WIDTH;

  typedef struct packed {
    logic                       vld;
    logic [BUF_IN_ENTRY_SZ-1:0] ent;
  } slot_t;

  typedef enum logic {IDLE, PKT} state_t;

  logic [S_KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0] data_p;
  logic [S_KEEP_WIDTH-1:0][LW-1:0]           beat_ent;
  slot_t  or_q, or_n, sk_q, sk_n;
  state_t state;
  logic   acc, emit, cons;

  for (genvar g = 0; g < S_KEEP_WIDTH; g++) begin : g_lane
    assign data_p[g] = s_data_i[g];
    slave_lane #(.KW(S_KEEP_WIDTH), .DW(T_DATA_WIDTH), .LANE(g)) u_lane (
      .keep (s_keep_i),
      .last (s_last_i),
      .data (data_p),
      .ent  (beat_ent[g])
    );
  end

  assign acc  = s_valid_i && s_ready_o;
  assign emit = acc && ((|s_keep_i) || s_last_i);
  assign cons = or_q.vld && !overflow;

  // Consumption first (SK refills OR), then the new entry lands in the first free slot.
  always_comb begin
    or_n = or_q;
    sk_n = sk_q;
    if (cons) begin
      or_n     = sk_q;
      sk_n.vld = 1'b0;
    end
    if (emit) begin
      if (!or_n.vld) or_n = '{vld: 1'b1, ent: beat_ent};
      else           sk_n = '{vld: 1'b1, ent: beat_ent};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_q      <= '0;
      sk_q      <= '0;
      s_ready_o <= 1'b0;
    end else begin
      or_q      <= or_n;
      sk_q      <= sk_n;
      s_ready_o <= !sk_n.vld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (acc) begin
      case (state)
        IDLE:    if (!s_last_i && (|s_keep_i)) state <= PKT;
        PKT:     if (s_last_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign slave_entry_valid = or_q.vld;
  assign slave_entry       = or_q.ent;
  assign in_packet_o       = (state == PKT);

`ifdef SLAVE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else if (acc) begin
      if (s_last_i)                pkt_cnt_o  <= pkt_cnt_o + 16'd1;
      else if (s_keep_i == '0)     drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_slave.sv
// Randomized and directed bench for slave; reference model is a queue of expected entries.
module tb_slave;
  localparam int KW = 3;
  localparam int DW = 8;
  localparam int LW = 2 + DW;
  localparam int EW = LW * KW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          s_last_i = 1'b0;
  logic          overflow = 1'b0;
  logic [KW-1:0] s_keep_i = '0;
  logic [DW-1:0] s_data_i [KW];
  logic          s_ready_o, slave_entry_valid, in_packet_o;
  logic [EW-1:0] slave_entry;
`ifdef SLAVE_STATS_EN
  logic [15:0]   pkt_cnt_o, drop_cnt_o;
  int            m_pkt = 0, m_drop = 0;
`endif

  int            checks = 0, passed = 0;
  logic [EW-1:0] q[$];
  bit            m_open = 0;

  slave #(.S_KEEP_WIDTH(KW), .T_DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_valid_i         (s_valid_i),
    .s_ready_o         (s_ready_o),
    .s_last_i          (s_last_i),
    .s_keep_i          (s_keep_i),
    .s_data_i          (s_data_i),
    .overflow          (overflow),
    .slave_entry_valid (slave_entry_valid),
    .slave_entry       (slave_entry),
    .in_packet_o       (in_packet_o)
`ifdef SLAVE_STATS_EN
    ,
    .pkt_cnt_o         (pkt_cnt_o),
    .drop_cnt_o        (drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Kept lanes listed in ascending order, packed from lane 0; last tags the final one.
  function automatic logic [EW-1:0] ref_entry(logic [KW-1:0] k, logic [DW-1:0] d [KW], logic l);
    logic [EW-1:0] e;
    int n;
    e = '0;
    n = 0;
    for (int i = 0; i < KW; i++) begin
      if (k[i]) begin
        e[n*LW +: LW] = {d[i], 2'b01};
        n++;
      end
    end
    if (l) e[((n == 0) ? 0 : n - 1) * LW + 1] = 1'b1;
    return e;
  endfunction

  task automatic drive(bit v, logic [KW-1:0] k, bit l);
    s_valid_i = v;
    s_keep_i  = k;
    s_last_i  = l;
    for (int i = 0; i < KW; i++) s_data_i[i] = DW'($urandom);
  endtask

  // One clock: model the handshakes from pre-edge values, then advance past the edge.
  task automatic cyc(output bit got, output logic [EW-1:0] act, output logic [EW-1:0] exp);
    bit acc, cons;
    acc  = s_valid_i && s_ready_o;
    cons = slave_entry_valid && !overflow;
    got  = 0;
    act  = '0;
    exp  = '0;
    if (cons) begin
      got = 1;
      act = slave_entry;
      exp = (q.size() > 0) ? q.pop_front() : ~slave_entry;
    end
    if (acc) begin
      if (s_keep_i != '0 || s_last_i) q.push_back(ref_entry(s_keep_i, s_data_i, s_last_i));
      if (s_last_i) m_open = 0;
      else if (s_keep_i != '0) m_open = 1;
`ifdef SLAVE_STATS_EN
      if (s_last_i) m_pkt++;
      else if (s_keep_i == '0) m_drop++;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (slave_entry_valid !== 1'b0 || s_ready_o !== 1'b0 || in_packet_o !== 1'b0 || slave_entry !== '0)
      $display("FAIL reset_state: valid=%b ready=%b inpkt=%b entry=%h, required all 0",
               slave_entry_valid, s_ready_o, in_packet_o, slave_entry);
    else passed++;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_ready_o !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", s_ready_o);
    else passed++;
  endtask

  task automatic test_compact();
    bit g;
    logic [EW-1:0] a, e, c;
    c = {{LW{1'b0}}, {8'h33, 2'b11}, {8'h11, 2'b01}};
    drive(1, 3'b101, 1);
    s_data_i[0] = 8'h11;
    s_data_i[1] = 8'h22;
    s_data_i[2] = 8'h33;
    cyc(g, a, e);
    drive(0, '0, 0);
    checks++;
    if (slave_entry_valid !== 1'b1 || slave_entry !== c)
      $display("FAIL compact_entry: valid=%b entry=%h required 1/%h", slave_entry_valid, slave_entry, c);
    else passed++;
    checks++;
    if (in_packet_o !== 1'b0) $display("FAIL compact_inpkt: got %b required 0", in_packet_o);
    else passed++;
    cyc(g, a, e);
    checks++;
    if (!g || a !== e) $display("FAIL compact_consume: got=%b entry=%h required %h", g, a, e);
    else passed++;
  endtask

  task automatic test_overflow();
    bit g;
    logic [EW-1:0] a, e;
    int n;
    overflow = 1'b1;
    drive(1, 3'b111, 0);
    cyc(g, a, e);
    drive(1, 3'b011, 0);
    cyc(g, a, e);
    checks++;
    if (s_ready_o !== 1'b0 || q.size() != 2)
      $display("FAIL ovf_ready_low: ready=%b held=%0d required 0/2", s_ready_o, q.size());
    else passed++;
    drive(1, 3'b110, 1);
    cyc(g, a, e);
    checks++;
    if (s_ready_o !== 1'b0 || q.size() != 2 || !slave_entry_valid)
      $display("FAIL ovf_third_held: ready=%b held=%0d valid=%b required 0/2/1",
               s_ready_o, q.size(), slave_entry_valid);
    else passed++;
    overflow = 1'b0;
    n = 0;
    for (int i = 0; i < 12 && (s_valid_i || q.size() > 0); i++) begin
      if (s_valid_i && s_ready_o) begin
        cyc(g, a, e);
        s_valid_i = 1'b0;
      end else cyc(g, a, e);
      if (g) begin
        n++;
        checks++;
        if (a !== e) $display("FAIL ovf_order: entry=%h required %h", a, e);
        else passed++;
      end
    end
    checks++;
    if (n != 3 || q.size() != 0 || in_packet_o !== 1'b0)
      $display("FAIL ovf_drain: drained=%0d left=%0d inpkt=%b required 3/0/0", n, q.size(), in_packet_o);
    else passed++;
  endtask

  task automatic test_null_last();
    bit g;
    logic [EW-1:0] a, e, c;
    int n;
    c = '0;
    c[1] = 1'b1;
    drive(1, 3'b000, 0);
    cyc(g, a, e);
    drive(0, '0, 0);
    checks++;
    if (slave_entry_valid !== 1'b0) $display("FAIL drop_no_entry: valid=%b required 0", slave_entry_valid);
    else passed++;
`ifdef SLAVE_STATS_EN
    checks++;
    if (drop_cnt_o !== 16'(m_drop) || m_drop != 1)
      $display("FAIL drop_cnt: got %0d required %0d", drop_cnt_o, m_drop);
    else passed++;
`endif
    drive(1, 3'b111, 0);
    cyc(g, a, e);
    checks++;
    if (in_packet_o !== 1'b1) $display("FAIL null_open: inpkt=%b required 1", in_packet_o);
    else passed++;
    drive(1, 3'b000, 1);
    cyc(g, a, e);
    drive(0, '0, 0);
    checks++;
    if (in_packet_o !== 1'b0) $display("FAIL null_close: inpkt=%b required 0", in_packet_o);
    else passed++;
    checks++;
    if (slave_entry_valid !== 1'b1 || slave_entry !== c)
      $display("FAIL null_last_entry: valid=%b entry=%h required 1/%h", slave_entry_valid, slave_entry, c);
    else passed++;
    n = 0;
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      cyc(g, a, e);
      if (g) n++;
    end
    checks++;
    if (n != 1 || q.size() != 0) $display("FAIL null_drain: drained=%0d left=%0d required 1/0", n, q.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit g;
    logic [EW-1:0] a, e;
    overflow = 1'b1;
    drive(1, 3'b111, 0);
    cyc(g, a, e);
    drive(1, 3'b101, 0);
    cyc(g, a, e);
    drive(0, '0, 0);
    checks++;
    if (q.size() != 2 || in_packet_o !== 1'b1 || s_ready_o !== 1'b0)
      $display("FAIL mid_setup: held=%0d inpkt=%b ready=%b required 2/1/0", q.size(), in_packet_o, s_ready_o);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (slave_entry_valid !== 1'b0 || s_ready_o !== 1'b0 || in_packet_o !== 1'b0)
      $display("FAIL mid_reset_now: valid=%b ready=%b inpkt=%b required 0/0/0",
               slave_entry_valid, s_ready_o, in_packet_o);
    else passed++;
    q.delete();
    m_open = 0;
`ifdef SLAVE_STATS_EN
    m_pkt  = 0;
    m_drop = 0;
`endif
    #1 rst_n = 1'b1;
    overflow = 1'b0;
    cyc(g, a, e);
    checks++;
    if (s_ready_o !== 1'b1 || slave_entry_valid !== 1'b0)
      $display("FAIL mid_release: ready=%b valid=%b required 1/0", s_ready_o, slave_entry_valid);
    else passed++;
    for (int i = 0; i < 3; i++) cyc(g, a, e);
    checks++;
    if (slave_entry_valid !== 1'b0 || g) $display("FAIL mid_no_stale: valid=%b required 0", slave_entry_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit g;
    logic [EW-1:0] a, e;
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, KW'($urandom_range(1, 7)), (i % 5) == 4);
      cyc(g, a, e);
      if (s_ready_o !== 1'b1 || (i > 0 && !g) || (g && a !== e)) bad++;
    end
    drive(0, '0, 0);
    cyc(g, a, e);
    checks++;
    if (bad != 0 || !g || a !== e || q.size() != 0)
      $display("FAIL b2b_stream: bad_cycles=%0d last=%h required 0 bad, %h", bad, a, e);
    else passed++;
  endtask

  task automatic test_random();
    bit g;
    logic [EW-1:0] a, e;
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, KW'($urandom), $urandom_range(0, 9) < 3);
      overflow = $urandom_range(0, 9) < 4;
      cyc(g, a, e);
      if (g) begin
        checks++;
        if (a !== e) $display("FAIL rnd_entry: cycle %0d entry=%h required %h", i, a, e);
        else passed++;
      end
      checks++;
      if (slave_entry_valid !== (q.size() > 0) || s_ready_o !== (q.size() < 2) || in_packet_o !== m_open)
        $display("FAIL rnd_flags: cycle %0d valid=%b ready=%b inpkt=%b required %b/%b/%b", i,
                 slave_entry_valid, s_ready_o, in_packet_o, q.size() > 0, q.size() < 2, m_open);
      else passed++;
    end
    drive(0, '0, 0);
    overflow = 1'b0;
    for (int i = 0; i < 6 && q.size() > 0; i++) begin
      cyc(g, a, e);
      if (g) begin
        checks++;
        if (a !== e) $display("FAIL rnd_drain: entry=%h required %h", a, e);
        else passed++;
      end
    end
    checks++;
    if (q.size() != 0 || slave_entry_valid !== 1'b0)
      $display("FAIL rnd_empty: left=%0d valid=%b required 0/0", q.size(), slave_entry_valid);
    else passed++;
`ifdef SLAVE_STATS_EN
    checks++;
    if (pkt_cnt_o !== 16'(m_pkt) || drop_cnt_o !== 16'(m_drop))
      $display("FAIL rnd_stats: pkt=%0d drop=%0d required %0d/%0d", pkt_cnt_o, drop_cnt_o, m_pkt, m_drop);
    else passed++;
`endif
  endtask

  initial begin
    for (int i = 0; i < KW; i++) s_data_i[i] = '0;
    test_reset();
    test_compact();
    test_overflow();
    test_null_last();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/slave.md
SLAVE -- requirements
Module: slave

Interface
REQ-001 The block SHALL have parameter S_KEEP_WIDTH, default 3, number of input lanes per beat.
REQ-002 The block SHALL have parameter T_DATA_WIDTH, default 1, data bits per lane.
REQ-003 The block SHALL have parameter BUF_IN_ENTRY_SZ, default (2+T_DATA_WIDTH)*S_KEEP_WIDTH, entry width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all flops on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 The block SHALL have port s_valid_i, input, 1, upstream beat valid.
REQ-007 The block SHALL have port s_ready_o, output, 1, block can accept a beat.
REQ-008 The block SHALL have port s_last_i, input, 1, beat ends packet.
REQ-009 The block SHALL have port s_keep_i, input, S_KEEP_WIDTH, per-lane byte-enable.
REQ-010 The block SHALL have port s_data_i, input, T_DATA_WIDTH x S_KEEP_WIDTH unpacked, lane data.
REQ-011 The block SHALL have port overflow, input, 1, downstream buffer full; entry not taken.
REQ-012 The block SHALL have port slave_entry_valid, output, 1, slave_entry holds an entry.
REQ-013 The block SHALL have port slave_entry, output, BUF_IN_ENTRY_SZ, packed lane entries.
REQ-014 The block SHALL have port in_packet_o, output, 1, high while a packet is open.

Function
REQ-015 Lane i of slave_entry SHALL occupy bits [i*(2+T_DATA_WIDTH) +: 2+T_DATA_WIDTH]: bit 0 keep, bit 1 last, upper T_DATA_WIDTH bits data.
REQ-016 A beat SHALL be accepted on a rising edge with s_valid_i && s_ready_o.
REQ-017 Accepted beats SHALL be compacted: kept lanes move, in ascending order, to lanes 0..K-1 (K = popcount(s_keep_i)); unused lanes have keep=0, last=0, data=0.
REQ-018 Last bit SHALL be set only on lane K-1, and only when s_last_i=1.
REQ-019 Beat with s_keep_i=0, s_last_i=1 SHALL produce an entry with all keep=0, lane 0 last=1 (null-last).
REQ-020 Beat with s_keep_i=0, s_last_i=0 SHALL be accepted and dropped (no entry).
REQ-021 Datapath SHALL be an output register (OR) plus one skid register (SK); slave_entry_valid = OR occupied.
REQ-022 OR SHALL be consumed on any edge with slave_entry_valid && !overflow.
REQ-023 Latency SHALL be 1 cycle: beat accepted at edge N appears on slave_entry after edge N if OR empty or consumed at edge N; else it goes to SK.
REQ-024 SK SHALL move to OR on the edge OR is consumed; simultaneous accept then goes to SK.
REQ-025 s_ready_o SHALL be registered and equal to !(SK occupied after the current edge); no beat is ever lost.
REQ-026 Entry order SHALL equal acceptance order.
REQ-027 FSM SHALL have states IDLE and PKT; IDLE->PKT on accepted non-last beat with keep!=0; PKT->IDLE on accepted last beat; otherwise hold; in_packet_o = (state==PKT).
REQ-028 Accepted last beat in IDLE SHALL emit normally and stay IDLE (single-beat packet).

Reset
REQ-029 rst_n low SHALL immediately clear OR, SK, FSM (IDLE), slave_entry_valid=0, slave_entry=0, s_ready_o=0, in_packet_o=0.
REQ-030 s_ready_o SHALL rise on the first clk edge after rst_n deasserts.
REQ-031 Reset mid-packet SHALL discard all held entries; no partial entry is emitted afterward.

Configuration
REQ-032 With SLAVE_STATS_EN defined, the block SHALL add outputs pkt_cnt_o[15:0] (accepted last beats) and drop_cnt_o[15:0] (beats dropped per REQ-020), wrapping at 16'hFFFF->0, cleared by reset.
REQ-033 Without SLAVE_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Verification (S_KEEP_WIDTH=3, T_DATA_WIDTH=8)
REQ-034 Keep=3'b101, data {C,B,A}=8'h33/22/11, last=1, overflow=0 -> next cycle entry lane0 {11,keep1,last0}, lane1 {33,keep1,last1}, lane2 zero; in_packet_o stays 0.
REQ-035 overflow=1 held, three beats offered -> two accepted, s_ready_o low after second; release overflow -> entries in order, third beat accepted after SK drains.
REQ-036 Keep=0, last=0 beat -> no slave_entry_valid; with SLAVE_STATS_EN drop_cnt_o=1.
REQ-037 Keep=0, last=1 after a keep=3'b111 non-last beat -> in_packet_o 1 then 0; second entry lane0 last=1, all keep=0.
REQ-038 rst_n pulsed low with OR and SK full mid-packet -> slave_entry_valid=0, s_ready_o=0, in_packet_o=0 at once; s_ready_o=1 one edge after release.
